// File: rtl/instr_mem_loadable_pkg.sv
// Shared types and default sizes for the loadable instruction memory.
package instr_mem_pkg;

    // Controller states: waiting for a program, streaming one in, serving fetches.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Load and fetch bus of the instruction memory. The master side is the
// loader plus core fetch stage; the slave side is the memory itself.
interface instr_mem_loadable_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              load_start;
    logic              load_valid;
    logic              load_last;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;
    logic [ADDR_W:0]   prog_len;
    logic              busy;

    modport master (
        output load_start, load_valid, load_last, load_data, fetch_req, fetch_addr,
        input  load_ready, load_done, fetch_valid, fetch_data, fetch_err, prog_len, busy
    );

    modport slave (
        input  load_start, load_valid, load_last, load_data, fetch_req, fetch_addr,
        output load_ready, load_done, fetch_valid, fetch_data, fetch_err, prog_len, busy
    );
endinterface

// File: rtl/instr_mem_loadable_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Contents are deliberately not reset; a read in the same cycle as a write to
// the same address returns the word stored before the write.
module imem_ram_1r1w #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, read-before-write on address collision.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: streamed program load under a small FSM,
// program-length tracking, and a one-cycle-latency fetch port that flags
// requests outside the loaded program.
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    instr_mem_loadable_if.slave  bus
);
    localparam int RAM_AW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   wptr_reg, wptr_next;
    logic [ADDR_W:0]   prog_len_reg, prog_len_next;
    logic              load_done_reg, load_done_next;
    logic              fetch_valid_reg;
    logic              fetch_err_reg;
    logic              fetch_ok_reg;
    logic              fetch_ok;
    logic              wr_en;
    logic [DATA_W-1:0] ram_rdata;

    // Controller state, write pointer, program length and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            wptr_reg      <= '0;
            prog_len_reg  <= '0;
            load_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wptr_reg      <= wptr_next;
            prog_len_reg  <= prog_len_next;
            load_done_reg <= load_done_next;
        end
    end

    // Next-state logic. A start in any state (re)enters LOAD with an empty
    // program; a start in LOAD wins over a word offered in the same cycle.
    // The load closes on the flagged last word or when the RAM is full.
    always_comb begin
        state_next     = state_reg;
        wptr_next      = wptr_reg;
        prog_len_next  = prog_len_reg;
        load_done_next = 1'b0;
        wr_en          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.load_start) begin
                    state_next    = LOAD;
                    wptr_next     = '0;
                    prog_len_next = '0;
                end
            end
            LOAD: begin
                if (bus.load_start) begin
                    wptr_next     = '0;
                    prog_len_next = '0;
                end else if (bus.load_valid) begin
                    wr_en     = 1'b1;
                    wptr_next = wptr_reg + 1'b1;
                    if (bus.load_last || (wptr_reg == LAST_PTR)) begin
                        prog_len_next  = wptr_reg + 1'b1;
                        load_done_next = 1'b1;
                        state_next     = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.load_start) begin
                    state_next    = LOAD;
                    wptr_next     = '0;
                    prog_len_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A fetch is served only in RUN and inside the loaded program; since
    // prog_len never exceeds DEPTH this also keeps the RAM index in range.
    always_comb begin
        fetch_ok = bus.fetch_req && (state_reg == RUN) &&
                   ({1'b0, bus.fetch_addr} < prog_len_reg);
    end

    // Fetch result flags, aligned with the registered RAM read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
            fetch_ok_reg    <= 1'b0;
        end else begin
            fetch_valid_reg <= bus.fetch_req;
            fetch_err_reg   <= bus.fetch_req && !fetch_ok;
            fetch_ok_reg    <= fetch_ok;
        end
    end

    imem_ram_1r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wptr_reg[RAM_AW-1:0]),
        .wr_data (bus.load_data),
        .rd_addr (bus.fetch_addr[RAM_AW-1:0]),
        .rd_data (ram_rdata)
    );

    // Data is forced to zero unless the request was served, so errors,
    // idle cycles and reset never expose raw RAM contents.
    assign bus.fetch_data  = fetch_ok_reg ? ram_rdata : '0;
    assign bus.fetch_valid = fetch_valid_reg;
    assign bus.fetch_err   = fetch_err_reg;
    assign bus.load_ready  = (state_reg == LOAD);
    assign bus.busy        = (state_reg == LOAD);
    assign bus.load_done   = load_done_reg;
    assign bus.prog_len    = prog_len_reg;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: a 256-word and a 4-word instance share one
// stimulus stream and are checked every cycle against a program-level model.
module tb_instr_mem_loadable;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_loadable_if #(.DATA_W(8), .ADDR_W(8)) if_a ();
    instr_mem_loadable_if #(.DATA_W(8), .ADDR_W(8)) if_b ();

    instr_mem_loadable #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
    instr_mem_loadable #(.DATA_W(8), .ADDR_W(8), .DEPTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b.slave));

    // Shared stimulus
    logic       s_start = 0, s_valid = 0, s_last = 0, s_req = 0;
    logic [7:0] s_data = 0, s_addr = 0;
    assign if_a.load_start = s_start;  assign if_b.load_start = s_start;
    assign if_a.load_valid = s_valid;  assign if_b.load_valid = s_valid;
    assign if_a.load_last  = s_last;   assign if_b.load_last  = s_last;
    assign if_a.load_data  = s_data;   assign if_b.load_data  = s_data;
    assign if_a.fetch_req  = s_req;    assign if_b.fetch_req  = s_req;
    assign if_a.fetch_addr = s_addr;   assign if_b.fetch_addr = s_addr;

    int n_tests = 0;
    int n_fail  = 0;
    bit verbose = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = no program, 1 = loading, 2 = program ready.
    int         depth_of [2] = '{256, 4};
    int         m_phase  [2];
    int         m_cnt    [2];
    int         m_plen   [2];
    logic [7:0] m_mem    [2][256];
    bit         e_valid  [2];
    bit         e_err    [2];
    bit         e_done   [2];
    logic [7:0] e_data   [2];

    task automatic model_step(input int d);
        int  a;
        bit  ok;
        a  = int'(s_addr);
        ok = s_req && (m_phase[d] == 2) && (a < m_plen[d]);
        e_valid[d] = s_req;
        e_err[d]   = s_req && !ok;
        e_data[d]  = ok ? m_mem[d][a] : 8'h00;
        e_done[d]  = 0;
        if (s_start) begin
            m_phase[d] = 1;
            m_cnt[d]   = 0;
            m_plen[d]  = 0;
        end else if (m_phase[d] == 1 && s_valid) begin
            m_mem[d][m_cnt[d]] = s_data;
            m_cnt[d] = m_cnt[d] + 1;
            if (s_last || m_cnt[d] == depth_of[d]) begin
                m_plen[d]  = m_cnt[d];
                m_phase[d] = 2;
                e_done[d]  = 1;
            end
        end
    endtask

    task automatic model_reset(input int d);
        m_phase[d] = 0; m_cnt[d] = 0; m_plen[d] = 0;
        e_valid[d] = 0; e_err[d] = 0; e_done[d] = 0; e_data[d] = 8'h00;
    endtask

    task automatic cmp_dut(input string tag, input int d,
                           input logic ready, input logic busy, input logic done,
                           input logic valid, input logic err, input logic [7:0] data,
                           input logic [8:0] plen);
        check({tag, ".load_ready"},  32'(ready), 32'(m_phase[d] == 1));
        check({tag, ".busy"},        32'(busy),  32'(m_phase[d] == 1));
        check({tag, ".load_done"},   32'(done),  32'(e_done[d]));
        check({tag, ".fetch_valid"}, 32'(valid), 32'(e_valid[d]));
        check({tag, ".fetch_err"},   32'(err),   32'(e_err[d]));
        check({tag, ".fetch_data"},  32'(data),  32'(e_data[d]));
        check({tag, ".prog_len"},    32'(plen),  32'(m_plen[d]));
    endtask

    // Single compare process: advance the model on each edge, check 1 ns later.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) model_reset(d);
            else          model_step(d);
        end
        #1;
        cmp_dut("a", 0, if_a.load_ready, if_a.busy, if_a.load_done, if_a.fetch_valid,
                if_a.fetch_err, if_a.fetch_data, if_a.prog_len);
        cmp_dut("b", 1, if_b.load_ready, if_b.busy, if_b.load_done, if_b.fetch_valid,
                if_b.fetch_err, if_b.fetch_data, if_b.prog_len);
        if (verbose && e_valid[0])
            $display("[TB] fetch addr_a=%02h err=%0b data=%02h | b err=%0b data=%02h",
                     dut_a.u_ram.rd_addr, if_a.fetch_err, if_a.fetch_data,
                     if_b.fetch_err, if_b.fetch_data);
        if (verbose && (e_done[0] || e_done[1]))
            $display("[TB] load done a=%0b len=%0d | b=%0b len=%0d",
                     if_a.load_done, if_a.prog_len, if_b.load_done, if_b.prog_len);
    end

    // Drive one cycle of inputs starting at the falling edge.
    task automatic drive(input bit st, input bit v, input bit last, input logic [7:0] d,
                         input bit rq, input logic [7:0] a);
        @(negedge clk);
        s_start = st; s_valid = v; s_last = last; s_data = d; s_req = rq; s_addr = a;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) model_reset(d);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset.prog_len", 32'(if_a.prog_len), 32'd0);
        check("reset.busy", 32'(if_a.busy), 32'd0);
        check("reset.fetch_valid", 32'(if_a.fetch_valid), 32'd0);

        // 1: fetch before any load errors
        drive(0, 0, 0, 8'h00, 1, 8'h00); settle();
        check("t1.valid", 32'(if_a.fetch_valid), 32'd1);
        check("t1.err",   32'(if_a.fetch_err),   32'd1);
        check("t1.data",  32'(if_a.fetch_data),  32'd0);
        check("t1.plen",  32'(if_a.prog_len),    32'd0);

        // 2: three-word load, then read back
        drive(1, 0, 0, 8'h00, 0, 8'h00);
        drive(0, 1, 0, 8'h11, 0, 8'h00);
        drive(0, 1, 0, 8'h22, 0, 8'h00);
        drive(0, 1, 1, 8'h33, 0, 8'h00); settle();
        check("t2.done", 32'(if_a.load_done), 32'd1);
        check("t2.plen", 32'(if_a.prog_len),  32'd3);
        check("t2.busy", 32'(if_a.busy),      32'd0);
        drive(0, 0, 0, 8'h00, 1, 8'h00); settle();
        check("t2.data0", 32'(if_a.fetch_data), 32'h11);
        check("t2.done_low", 32'(if_a.load_done), 32'd0);
        drive(0, 0, 0, 8'h00, 1, 8'h01); settle();
        check("t2.data1", 32'(if_a.fetch_data), 32'h22);
        drive(0, 0, 0, 8'h00, 1, 8'h02); settle();
        check("t2.data2", 32'(if_a.fetch_data), 32'h33);
        check("t2.err2",  32'(if_a.fetch_err),  32'd0);

        // 3: out-of-program addresses
        drive(0, 0, 0, 8'h00, 1, 8'h03); settle();
        check("t3.err3",  32'(if_a.fetch_err),  32'd1);
        check("t3.data3", 32'(if_a.fetch_data), 32'd0);
        drive(0, 0, 0, 8'h00, 1, 8'hFF); settle();
        check("t3.errFF", 32'(if_a.fetch_err),  32'd1);

        // 4: overlong stream into the 4-word instance
        drive(1, 0, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 8'hC0 + 8'(i), 0, 8'h00);
            if (i == 3) begin
                settle();
                check("t4.b_ready", 32'(if_b.load_ready), 32'd0);
                check("t4.b_plen",  32'(if_b.prog_len),   32'd4);
                check("t4.b_done",  32'(if_b.load_done),  32'd1);
            end
        end
        drive(0, 1, 1, 8'hC6, 0, 8'h00);
        drive(0, 0, 0, 8'h00, 1, 8'h03); settle();
        check("t4.b_data3", 32'(if_b.fetch_data), 32'hC3);
        check("t4.a_plen",  32'(if_a.prog_len),   32'd7);
        drive(0, 0, 0, 8'h00, 1, 8'h04); settle();
        check("t4.b_err4",  32'(if_b.fetch_err),  32'd1);

        // 5: restart mid-load with a word in the same cycle
        drive(1, 0, 0, 8'h00, 0, 8'h00);
        drive(0, 1, 0, 8'h01, 0, 8'h00);
        drive(0, 1, 0, 8'h02, 0, 8'h00);
        drive(1, 1, 0, 8'h55, 0, 8'h00);
        drive(0, 1, 0, 8'hAA, 0, 8'h00);
        drive(0, 1, 1, 8'hBB, 0, 8'h00); settle();
        check("t5.plen", 32'(if_a.prog_len), 32'd2);
        drive(0, 0, 0, 8'h00, 1, 8'h00); settle();
        check("t5.data0", 32'(if_a.fetch_data), 32'hAA);
        check("t5.b_data0", 32'(if_b.fetch_data), 32'hAA);

        // Randomised traffic
        verbose = 0;
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) < 3), $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0), 8'($urandom),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
        end
        verbose = 1;

        // 6: asynchronous reset in the middle of a load
        drive(1, 0, 0, 8'h00, 0, 8'h00);
        drive(0, 1, 0, 8'h77, 0, 8'h00); settle();
        check("t6.busy_before", 32'(if_a.busy), 32'd1);
        #1;
        reset_n = 1'b0;
        s_start = 0; s_valid = 0; s_last = 0; s_req = 0;
        #1;
        check("t6.busy",  32'(if_a.busy),       32'd0);
        check("t6.ready", 32'(if_a.load_ready), 32'd0);
        check("t6.plen",  32'(if_a.prog_len),   32'd0);
        check("t6.valid", 32'(if_a.fetch_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 8'h00, 1, 8'h00); settle();
        check("t6.err_after", 32'(if_a.fetch_err), 32'd1);
        check("t6.b_err_after", 32'(if_b.fetch_err), 32'd1);
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
